tf_block_sequencer: RTL and testbench

TF_BLOCK_SEQUENCER -- requirements
Module: tf_block_sequencer

---
 rtl/tf_block_sequencer.sv | 153 +++++++++++++++
 tb/tb_tf_block_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tf_block_sequencer.sv
// tf_block_sequencer
// Feeds a 128-bit key and a 128-bit plaintext, collected as eight 32-bit words,
// to an encryption core. It pulses the core's reset/start for one cycle and waits
// CORE_LAT cycles. It then latches the ciphertext and drains it as four 32-bit
// words over a valid/ready stream, with out_last on the fourth word.
//
// Optional build macro TF_SEQ_KEY_REUSE_EN adds the in_key_keep input. When that
// input is high on the first word of a block, the block is only four plaintext
// words and the previous key is reused. Without the macro every block carries a
// fresh key.
module tf_block_sequencer #(
    parameter int CORE_LAT = 25
) (
    input  logic         clk,
    input  logic         reset,
`ifdef TF_SEQ_KEY_REUSE_EN
    input  logic         in_key_keep,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [127:0] core_key,
    output logic [127:0] core_pt,
    output logic         core_reset,
    input  logic [127:0] core_ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         busy
);

    // The wait counter runs 0 .. CORE_LAT-1.
    localparam int                WAIT_W    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t              state;
    logic [2:0]          wcnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [127:0]        ct_q;

    logic                in_xfer;
    logic [2:0]          load_idx;
    logic [6:0]          lane_lsb;

    // Word 0 of a 128-bit value is its most significant 32 bits.
    function automatic logic [31:0] ct_word(input logic [127:0] ct, input logic [1:0] idx);
        return ct[{~idx, 5'b00000} +: 32];
    endfunction

    // in_ready is gated by reset so that it is low while reset is held and rises
    // on the first cycle after reset falls.
    assign in_ready = (state == ST_LOAD) && !reset;
    assign in_xfer  = in_valid && in_ready;

    // Slot written by the current load word. With key reuse, the first word of
    // the block skips straight to plaintext slot 4.
    always_comb begin
        load_idx = wcnt;
`ifdef TF_SEQ_KEY_REUSE_EN
        if (wcnt == 3'd0 && in_key_keep) begin
            load_idx = 3'd4;
        end
`endif
        lane_lsb = {~load_idx[1:0], 5'b00000};
    end

    // Block sequencing FSM. It owns the key/plaintext/ciphertext registers and
    // all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_LOAD;
            wcnt       <= 3'd0;
            wait_cnt   <= '0;
            core_key   <= '0;
            core_pt    <= '0;
            ct_q       <= '0;
            core_reset <= 1'b1;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    core_reset <= 1'b0;
                    if (in_xfer) begin
                        if (load_idx[2]) begin
                            core_pt[lane_lsb +: 32] <= in_data;
                        end else begin
                            core_key[lane_lsb +: 32] <= in_data;
                        end
                        if (load_idx == 3'd7) begin
                            state      <= ST_START;
                            wcnt       <= 3'd0;
                            busy       <= 1'b1;
                            core_reset <= 1'b1;
                        end else begin
                            wcnt <= load_idx + 3'd1;
                        end
                    end
                end

                // Core reset was high for exactly this one cycle.
                ST_START: begin
                    core_reset <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= ST_WAIT;
                end

                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        ct_q      <= core_ct;
                        out_valid <= 1'b1;
                        out_data  <= ct_word(core_ct, 2'd0);
                        out_last  <= 1'b0;
                        state     <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (out_ready) begin
                        if (wcnt == 3'd3) begin
                            state     <= ST_LOAD;
                            wcnt      <= 3'd0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            busy      <= 1'b0;
                        end else begin
                            wcnt     <= wcnt + 3'd1;
                            out_data <= ct_word(ct_q, wcnt[1:0] + 2'd1);
                            out_last <= (wcnt == 3'd2);
                        end
                    end
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tf_block_sequencer.sv
// Directed testbench for tf_block_sequencer. It contains a stand-in encryption
// core whose ciphertext is valid only on the exact cycle CORE_LAT cycles after
// core_reset falls.
module tb_tf_block_sequencer;

    localparam int LAT = 25;
    localparam logic [127:0] TWOFISH_Z = 128'h9F589F5C_F6122C32_B6BFEC2F_2AE8C35A;
    localparam logic [127:0] GARBAGE   = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    localparam logic [127:0] KA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] PA = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] KB = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
    localparam logic [127:0] PB = 128'hCAFEBABE_DEADC0DE_00000001_80000000;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [127:0] core_key;
    logic [127:0] core_pt;
    logic         core_reset;
    logic [127:0] core_ct;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;
`ifdef TF_SEQ_KEY_REUSE_EN
    logic         in_key_keep;
`endif

    int tests  = 0;
    int failed = 0;
    int lat_cnt = 0;

    always #5 clk = ~clk;

    tf_block_sequencer #(.CORE_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef TF_SEQ_KEY_REUSE_EN
        .in_key_keep(in_key_keep),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .core_key   (core_key),
        .core_pt    (core_pt),
        .core_reset (core_reset),
        .core_ct    (core_ct),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    // Stand-in core: zero key with zero plaintext gives the Twofish reference
    // ciphertext; anything else gives an arbitrary mix.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == '0 && p == '0) return TWOFISH_Z;
        return k ^ {p[63:0], p[127:64]} ^ {4{32'h5A5A5A5A}};
    endfunction

    always @(posedge clk) begin
        if (core_reset === 1'b1) lat_cnt <= 0;
        else if (lat_cnt < LAT) lat_cnt <= lat_cnt + 1;
    end
    assign core_ct = (lat_cnt == LAT - 1) ? core_fn(core_key, core_pt) : GARBAGE;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Offers one word from a falling edge and returns on the falling edge after it transfers.
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 200) begin
            failed++;
            $display("FAIL send_word_timeout: in_ready=%b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] p, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) send_word(k[(3 - i) * 32 +: 32]);
            else       send_word(p[(7 - i) * 32 +: 32]);
            if (gaps && i < 7) @(negedge clk);
        end
    endtask

    // Collects up to four output words with out_ready high.
    task automatic drain_block(output logic [127:0] d, output logic [3:0] l, output int got);
        int n;
        d = '0;
        l = '0;
        got = 0;
        n = 0;
        out_ready = 1'b1;
        while (got < 4 && n < 300) begin
            if (out_valid === 1'b1) begin
                d[(3 - got) * 32 +: 32] = out_data;
                l[3 - got] = out_last;
                got++;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef TF_SEQ_KEY_REUSE_EN
        in_key_keep = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({in_ready, busy, core_reset, out_valid, out_last} !== 5'b00100) begin
            failed++;
            $display("FAIL reset_ctrl: {rdy,busy,crst,ov,last}=%b required=00100",
                     {in_ready, busy, core_reset, out_valid, out_last});
        end
        tests++;
        if (out_data !== 32'h0 || core_key !== '0 || core_pt !== '0) begin
            failed++;
            $display("FAIL reset_data: out_data=%h key=%h pt=%h required all zero", out_data, core_key, core_pt);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_release_ready: in_ready=%b required=1", in_ready);
        end
        @(negedge clk);
        tests++;
        if ({core_reset, busy} !== 2'b00) begin
            failed++;
            $display("FAIL reset_release_ctrl: {crst,busy}=%b required=00", {core_reset, busy});
        end
    endtask

    task automatic test_basic();
        logic [127:0] d; logic [3:0] l; int got; int n; int pulses;
        out_ready = 1'b1;
        send_block('0, '0, 1'b0);
        tests++;
        if ({core_reset, busy, in_ready} !== 3'b110) begin
            failed++;
            $display("FAIL basic_start: {crst,busy,rdy}=%b required=110", {core_reset, busy, in_ready});
        end
        n = 0; pulses = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (core_reset === 1'b1) pulses++;
        end
        tests++;
        if (n != LAT + 1) begin
            failed++;
            $display("FAIL basic_latency: cycles=%0d required=%0d", n, LAT + 1);
        end
        tests++;
        if (pulses != 0) begin
            failed++;
            $display("FAIL basic_core_reset_width: extra high cycles=%0d required=0", pulses);
        end
        drain_block(d, l, got);
        tests++;
        if (got != 4 || d !== TWOFISH_Z || l !== 4'b0001) begin
            failed++;
            $display("FAIL basic_ct: got=%0d data=%h last=%b required 4 %h 0001", got, d, l, TWOFISH_Z);
        end
        tests++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            failed++;
            $display("FAIL basic_return_load: {ov,busy,rdy}=%b required=001", {out_valid, busy, in_ready});
        end
    endtask

    task automatic test_stall();
        logic [127:0] d; logic [3:0] l; int got; int n; int bad;
        out_ready = 1'b0;
        send_block('0, '0, 1'b0);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid !== 1'b1 || out_data !== 32'h9F589F5C || out_last !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL stall_hold: bad cycles=%0d required=0 (out_data=%h)", bad, out_data);
        end
        drain_block(d, l, got);
        tests++;
        if (got != 4 || d !== TWOFISH_Z || l !== 4'b0001) begin
            failed++;
            $display("FAIL stall_ct: got=%0d data=%h last=%b required 4 %h 0001", got, d, l, TWOFISH_Z);
        end
    endtask

    task automatic test_gaps();
        logic [127:0] d; logic [3:0] l; int got;
        for (int g = 0; g < 2; g++) begin
            out_ready = 1'b1;
            send_block(KA, PA, g[0]);
            tests++;
            if (core_reset !== 1'b1 || core_key !== KA || core_pt !== PA) begin
                failed++;
                $display("FAIL gaps%0d_load: crst=%b key=%h pt=%h required 1 %h %h", g, core_reset, core_key, core_pt, KA, PA);
            end
            drain_block(d, l, got);
            tests++;
            if (got != 4 || d !== core_fn(KA, PA) || l !== 4'b0001) begin
                failed++;
                $display("FAIL gaps%0d_ct: got=%0d data=%h last=%b required 4 %h 0001", g, got, d, l, core_fn(KA, PA));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d; logic [3:0] l; int got; int n; int seen;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) send_word(KA[(3 - i) * 32 +: 32]);
            else       send_word(PA[127:96]);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (core_key !== '0 || core_pt !== '0 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL midload_reset: key=%h pt=%h rdy=%b required 0 0 0", core_key, core_pt, in_ready);
        end
        reset = 1'b0;
        #1;
        send_block(KB, PB, 1'b0);
        tests++;
        if (core_key !== KB || core_pt !== PB) begin
            failed++;
            $display("FAIL midload_newblock: key=%h pt=%h required %h %h", core_key, core_pt, KB, PB);
        end
        drain_block(d, l, got);
        tests++;
        if (got != 4 || d !== core_fn(KB, PB) || l !== 4'b0001 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL midload_ct: got=%0d data=%h last=%b ov=%b required 4 %h 0001 0", got, d, l, out_valid, core_fn(KB, PB));
        end
        // Abort in the middle of a drain.
        out_ready = 1'b0;
        send_block('0, '0, 1'b0);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({out_valid, out_last, busy} !== 3'b000 || out_data !== 32'h0) begin
            failed++;
            $display("FAIL middrain_reset: {ov,last,busy}=%b data=%h required 000 0", {out_valid, out_last, busy}, out_data);
        end
        reset = 1'b0;
        #1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            failed++;
            $display("FAIL middrain_stale: out_valid cycles=%0d required=0", seen);
        end
        send_block(KA, PA, 1'b0);
        drain_block(d, l, got);
        tests++;
        if (got != 4 || d !== core_fn(KA, PA) || l !== 4'b0001) begin
            failed++;
            $display("FAIL middrain_ct: got=%0d data=%h last=%b required 4 %h 0001", got, d, l, core_fn(KA, PA));
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] d; logic [3:0] l; int got; int n; int bad;
        out_ready = 1'b0;
        send_block(KA, PA, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        n = 0; bad = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (in_ready !== 1'b0 || core_pt !== PA || core_key !== KA) bad++;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        tests++;
        if (bad != 0 || n != LAT + 1) begin
            failed++;
            $display("FAIL busy_ignore: bad cycles=%0d latency=%0d required 0 %0d", bad, n, LAT + 1);
        end
        drain_block(d, l, got);
        tests++;
        if (got != 4 || d !== core_fn(KA, PA) || l !== 4'b0001) begin
            failed++;
            $display("FAIL busy_ct: got=%0d data=%h last=%b required 4 %h 0001", got, d, l, core_fn(KA, PA));
        end
        send_block(KB, PB, 1'b0);
        tests++;
        if (core_key !== KB || core_pt !== PB) begin
            failed++;
            $display("FAIL busy_nextblock: key=%h pt=%h required %h %h", core_key, core_pt, KB, PB);
        end
        drain_block(d, l, got);
        tests++;
        if (got != 4 || d !== core_fn(KB, PB)) begin
            failed++;
            $display("FAIL busy_next_ct: got=%0d data=%h required 4 %h", got, d, core_fn(KB, PB));
        end
    endtask

`ifdef TF_SEQ_KEY_REUSE_EN
    task automatic test_key_reuse();
        logic [127:0] d; logic [3:0] l; int got;
        in_key_keep = 1'b0;
        send_block('0, '0, 1'b0);
        drain_block(d, l, got);
        in_key_keep = 1'b1;
        send_word(32'h0);
        in_key_keep = 1'b0;
        for (int i = 0; i < 3; i++) send_word(32'h0);
        tests++;
        if (core_reset !== 1'b1 || core_key !== '0 || core_pt !== '0) begin
            failed++;
            $display("FAIL keep_zero_load: crst=%b key=%h pt=%h required 1 0 0", core_reset, core_key, core_pt);
        end
        drain_block(d, l, got);
        tests++;
        if (got != 4 || d !== TWOFISH_Z || l !== 4'b0001) begin
            failed++;
            $display("FAIL keep_zero_ct: got=%0d data=%h required 4 %h", got, d, TWOFISH_Z);
        end
        send_block(KA, PA, 1'b0);
        drain_block(d, l, got);
        in_key_keep = 1'b1;
        send_word(PB[127:96]);
        in_key_keep = 1'b0;
        send_word(PB[95:64]);
        send_word(PB[63:32]);
        send_word(PB[31:0]);
        tests++;
        if (core_reset !== 1'b1 || core_key !== KA || core_pt !== PB) begin
            failed++;
            $display("FAIL keep_nonzero_load: crst=%b key=%h pt=%h required 1 %h %h", core_reset, core_key, core_pt, KA, PB);
        end
        drain_block(d, l, got);
        tests++;
        if (got != 4 || d !== core_fn(KA, PB)) begin
            failed++;
            $display("FAIL keep_nonzero_ct: got=%0d data=%h required 4 %h", got, d, core_fn(KA, PB));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_gaps();
        test_reset_mid();
        test_busy_ignore();
`ifdef TF_SEQ_KEY_REUSE_EN
        test_key_reuse();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
